// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around sram_arbiter.
// The arbiter takes the slave view; the surrounding core/memory take the master view.
interface sram_arbiter_if;
  logic        flush;

  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [63:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [7:0]  ls_wstrb;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  logic        stallreq_if;
  logic        stallreq_ls;

  modport slave (
    input  flush,
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_wstrb, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output stallreq_if, stallreq_ls
  );

  modport master (
    output flush,
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_wstrb, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    output stallreq_if, stallreq_ls
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port (fetch, load/store) arbiter onto a single SRAM port, one transaction in flight.
// LS has priority; IF is forced through after STARVE_MAX consecutive losses.
module sram_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst_n,
  sram_arbiter_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q;
  logic        owner_ls_q;
  logic        kill_q;
  logic [3:0]  wait_cnt_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic        we_q;

  logic idle, if_win, ls_win, resp_valid, if_rv, ls_rv, req_phase;

  always_comb begin
    idle       = (state_q == StIdle);
    req_phase  = (state_q == StReq);
    // A flush in IDLE blocks the fetch grant but lets a pending LS through.
    if_win     = idle & bus.if_req & ~bus.flush & (~bus.ls_req | (wait_cnt_q == StarveMax));
    ls_win     = idle & bus.ls_req & ~if_win;
    resp_valid = bus.mem_rvalid & (state_q == StResp);
    if_rv      = resp_valid & ~owner_ls_q & ~kill_q;
    ls_rv      = resp_valid & owner_ls_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_ls_q <= 1'b0;
      kill_q     <= 1'b0;
      wait_cnt_q <= 4'd0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      wstrb_q    <= 8'd0;
      we_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (if_win) begin
            owner_ls_q <= 1'b0;
            addr_q     <= bus.if_addr;
            wdata_q    <= 64'd0;
            wstrb_q    <= 8'd0;
            we_q       <= 1'b0;
            wait_cnt_q <= 4'd0;
            state_q    <= StReq;
          end else if (ls_win) begin
            owner_ls_q <= 1'b1;
            addr_q     <= bus.ls_addr;
            wdata_q    <= bus.ls_wdata;
            wstrb_q    <= bus.ls_wstrb;
            we_q       <= bus.ls_we;
            if (bus.if_req && wait_cnt_q != StarveMax) wait_cnt_q <= wait_cnt_q + 4'd1;
            state_q    <= StReq;
          end
        end
        // A same-cycle rvalid here is ignored; the response is expected in StResp.
        StReq:   if (bus.mem_gnt) state_q <= StResp;
        StResp:  if (bus.mem_rvalid) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (!idle && !owner_ls_q && bus.flush) kill_q <= 1'b1;
      if (resp_valid) kill_q <= 1'b0;
    end
  end

  // Every output is forced low while reset is asserted, including the combinational ones.
  always_comb begin
    bus.if_gnt      = rst_n & if_win;
    bus.ls_gnt      = rst_n & ls_win;
    bus.mem_req     = rst_n & req_phase;
    bus.mem_we      = rst_n & req_phase & we_q;
    bus.mem_wstrb   = (rst_n & req_phase) ? wstrb_q : 8'd0;
    bus.mem_addr    = (rst_n & req_phase) ? addr_q : 64'd0;
    bus.mem_wdata   = (rst_n & req_phase) ? wdata_q : 64'd0;
    bus.if_rvalid   = rst_n & if_rv;
    bus.ls_rvalid   = rst_n & ls_rv;
    bus.if_rdata    = (rst_n & ~owner_ls_q) ? bus.mem_rdata : 64'd0;
    bus.ls_rdata    = (rst_n & owner_ls_q) ? bus.mem_rdata : 64'd0;
    bus.stallreq_if = rst_n & ~kill_q &
                      ((bus.if_req & ~if_win) | (~owner_ls_q & ~idle & ~if_rv));
    bus.stallreq_ls = rst_n & ((bus.ls_req & ~ls_win) | (owner_ls_q & ~idle & ~ls_rv));
  end

endmodule
